demodulator: RTL

DEMODULATOR -- requirements
Module: demodulator

---
 rtl/packet_pkg.sv | 15 +
 rtl/pkt_fifo.sv | 71 +++++++
 rtl/demodulator.sv | 106 ++++++++++
 3 files changed

// File: rtl/packet_pkg.sv
// Shared packet payload type and counter widths for the waveguide receive path.
package packet_pkg;

  localparam int unsigned DEST_W      = 32;
  localparam int unsigned TS_W        = 32;
  localparam int unsigned PAYLOAD_W   = 64;
  localparam int unsigned DEMOD_CNT_W = 16;

  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic [TS_W-1:0]      timestamp;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

endpackage

// File: rtl/pkt_fifo.sv
// Show-ahead packet FIFO with registered head, full, empty and occupancy.
module pkt_fifo
  import packet_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  packet_t          push_data,
  input  logic             pop,
  output packet_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  packet_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Qualify requests and compute next read pointer and occupancy.
  always_comb begin
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    rd_ptr_nxt = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt  = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, flags and the registered head entry. When the new write lands
  // at the next read slot (buffer empty after this cycle's pop) the head is
  // bypassed from push_data, since mem has not been written yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == CNT_W'(DEPTH));
      empty  <= (count_nxt == CNT_W'(0));
      head   <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? push_data : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/demodulator.sv
// Receiver node: photodetection delay line, destination filter, receive buffer
// and accept/overflow counters.
module demodulator
  import packet_pkg::*;
#(
  parameter int unsigned DELAY = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  packet_t                in_data,
  input  logic                   in_valid,
  input  logic [31:0]            node_id,
  output packet_t                out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEMOD_CNT_W-1:0] rx_count,
  output logic [DEMOD_CNT_W-1:0] drop_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned LAST  = DELAY - 1;

  packet_t          stage_pkt [DELAY];
  logic             stage_vld [DELAY];
  packet_t          last_pkt;
  logic             match;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Detection delay line; shifts every cycle regardless of buffer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        stage_pkt[i] <= '0;
        stage_vld[i] <= 1'b0;
      end
    end else begin
      stage_pkt[0] <= in_data;
      stage_vld[0] <= in_valid;
      for (int unsigned i = 1; i < DELAY; i++) begin
        stage_pkt[i] <= stage_pkt[i-1];
        stage_vld[i] <= stage_vld[i-1];
      end
    end
  end

  // Address filter and buffer admission; a full buffer still accepts when
  // the head leaves in the same cycle.
  always_comb begin
    last_pkt = stage_pkt[LAST];
    match    = stage_vld[LAST] && (last_pkt.dest == node_id);
    pop      = out_valid && out_ready;
    push     = match && (!fifo_full || pop);
    drop     = match && fifo_full && !pop;
  end

  assign out_valid = !fifo_empty;

  pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (last_pkt),
    .pop       (pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Accepted packets wrap; overflow losses saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        rx_count <= rx_count + DEMOD_CNT_W'(1);
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + DEMOD_CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // Arrival log and buffer flag consistency check.
  always @(posedge clk) begin
    if (!rst) begin
      if (push) begin
        $display("Demodulator %0d received packet ID %0d", node_id, last_pkt.timestamp);
      end
      assert (fifo_full == (fifo_count == CNT_W'(DEPTH)))
        else $error("demodulator: buffer full flag disagrees with occupancy");
    end
  end
`endif

endmodule
